// File: rtl/ball_ctrl.sv
// Breakout ball sequencer: per-frame move, wall/paddle reflection, brick query, serve and lives.
// Registered outputs; a move returns to MOVE no sooner than 4 cycles after the tick, and stalls in WAIT until brick_done.
module ball_ctrl #(
    parameter int SCREEN_W  = 320,
    parameter int SCREEN_H  = 240,
    parameter int WALL      = 8,
    parameter int BALL_SIZE = 4,
    parameter int PADDLE_Y  = 224,
    parameter int PADDLE_W  = 32,
    parameter int STEP      = 2,
    parameter int LIVES     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       launch,
    input  logic [8:0] paddle_x,
    input  logic       brick_done,
    input  logic       brick_hit,
    output logic [8:0] ball_x,
    output logic [7:0] ball_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic       check_req,
    output logic       life_lost,
    output logic [1:0] lives,
    output logic       game_over
);

    localparam logic [9:0] LEFT      = 10'(WALL);
    localparam logic [9:0] TOP       = 10'(WALL);
    localparam logic [9:0] RIGHT     = 10'(SCREEN_W - WALL - BALL_SIZE);
    localparam logic [9:0] REST      = 10'(PADDLE_Y - BALL_SIZE);
    localparam logic [9:0] FLOOR     = 10'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0] STEP_W    = 10'(STEP);
    localparam logic [9:0] PAD_W     = 10'(PADDLE_W);
    localparam logic [9:0] BALL_W    = 10'(BALL_SIZE);
    localparam logic [9:0] SERVE_OFS = 10'(PADDLE_W / 2 - BALL_SIZE / 2);
    localparam logic [9:0] START_X   = 10'(SCREEN_W / 2 - BALL_SIZE / 2);

    typedef enum logic [2:0] {
        S_SERVE, S_MOVE, S_EDGE, S_REQ, S_WAIT, S_LOST, S_OVER
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] ball_x_q, ball_x_d;
    logic [7:0] ball_y_q, ball_y_d;
    logic       dir_x_q, dir_x_d;
    logic       dir_y_q, dir_y_d;
    logic       check_req_q, check_req_d;
    logic       life_lost_q, life_lost_d;
    logic [1:0] lives_q, lives_d;
    logic       game_over_q, game_over_d;

    logic [9:0] x_w, y_w, px_w, nx, ny;
    logic       unused_hi_bits;

    assign x_w  = {1'b0, ball_x_q};
    assign y_w  = {2'b00, ball_y_q};
    assign px_w = {1'b0, paddle_x};
    assign unused_hi_bits = ^{nx[9], ny[9:8]};

    always_comb begin
        state_d     = state_q;
        nx          = x_w;
        ny          = y_w;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        check_req_d = 1'b0;
        life_lost_d = 1'b0;
        lives_d     = lives_q;
        game_over_d = game_over_q;

        case (state_q)
            S_SERVE: begin
                nx = px_w + SERVE_OFS;
                ny = REST;
                if (frame_tick && launch) begin
                    dir_x_d = 1'b1;
                    dir_y_d = 1'b0;
                    state_d = S_MOVE;
                end
            end
            S_MOVE: begin
                if (frame_tick) begin
                    if (!dir_x_q) begin
                        if (x_w <= LEFT + STEP_W) begin
                            nx      = LEFT;
                            dir_x_d = 1'b1;
                        end else begin
                            nx = x_w - STEP_W;
                        end
                    end else if (x_w + STEP_W >= RIGHT) begin
                        nx      = RIGHT;
                        dir_x_d = 1'b0;
                    end else begin
                        nx = x_w + STEP_W;
                    end
                    // Downward motion is unclamped so a missed ball can reach FLOOR.
                    if (!dir_y_q) begin
                        if (y_w <= TOP + STEP_W) begin
                            ny      = TOP;
                            dir_y_d = 1'b1;
                        end else begin
                            ny = y_w - STEP_W;
                        end
                    end else begin
                        ny = y_w + STEP_W;
                    end
                    state_d = S_EDGE;
                end
            end
            S_EDGE: begin
                if (dir_y_q && (y_w >= REST) && (y_w < REST + STEP_W) &&
                    (x_w + BALL_W > px_w) && (x_w < px_w + PAD_W)) begin
                    ny      = REST;
                    dir_y_d = 1'b0;
                    state_d = S_REQ;
                end else if (y_w >= FLOOR) begin
                    state_d = S_LOST;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                check_req_d = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (brick_done) begin
                    if (brick_hit) dir_y_d = ~dir_y_q;
                    state_d = S_MOVE;
                end
            end
            S_LOST: begin
                lives_d = lives_q - 2'd1;
                if (lives_q == 2'd1) begin
                    game_over_d = 1'b1;
                    state_d     = S_OVER;
                end else begin
                    life_lost_d = 1'b1;
                    state_d     = S_SERVE;
                end
            end
            S_OVER: begin
            end
            default: state_d = S_SERVE;
        endcase

        ball_x_d = nx[8:0];
        ball_y_d = ny[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_SERVE;
            ball_x_q    <= START_X[8:0];
            ball_y_q    <= REST[7:0];
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b0;
            check_req_q <= 1'b0;
            life_lost_q <= 1'b0;
            lives_q     <= 2'(LIVES);
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            check_req_q <= check_req_d;
            life_lost_q <= life_lost_d;
            lives_q     <= lives_d;
            game_over_q <= game_over_d;
        end
    end

    assign ball_x    = ball_x_q;
    assign ball_y    = ball_y_q;
    assign dir_x     = dir_x_q;
    assign dir_y     = dir_y_q;
    assign check_req = check_req_q;
    assign life_lost = life_lost_q;
    assign lives     = lives_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Directed bench for ball_ctrl: serve, walls, corner, paddle, brick handshake, lives, game over, reset.
module tb_ball_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       launch = 1'b0;
    logic [8:0] paddle_x = 9'd100;
    logic       brick_done = 1'b0;
    logic       brick_hit = 1'b0;
    logic [8:0] ball_x;
    logic [7:0] ball_y;
    logic       dir_x, dir_y, check_req, life_lost, game_over;
    logic [1:0] lives;

    int checks = 0;
    int errors = 0;

    ball_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .launch(launch),
        .paddle_x(paddle_x), .brick_done(brick_done), .brick_hit(brick_hit),
        .ball_x(ball_x), .ball_y(ball_y), .dir_x(dir_x), .dir_y(dir_y),
        .check_req(check_req), .life_lost(life_lost), .lives(lives), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_pos(input string tag, input int x, input int y);
        check({tag, "_x"}, 32'(ball_x), 32'(x));
        check({tag, "_y"}, 32'(ball_y), 32'(y));
    endtask

    task automatic check_reset_vals(input string tag);
        check_pos(tag, 158, 220);
        check({tag, "_dx"}, 32'(dir_x), 1);
        check({tag, "_dy"}, 32'(dir_y), 0);
        check({tag, "_lives"}, 32'(lives), 3);
        check({tag, "_req"}, 32'(check_req), 0);
        check({tag, "_lost"}, 32'(life_lost), 0);
        check({tag, "_over"}, 32'(game_over), 0);
    endtask

    task automatic do_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    // Entered at the negedge just after the tick edge; answers the brick query.
    task automatic respond(input logic hit, input int delay, input logic tick_wait);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!check_req && lat < 10);
        check("req_lat", 32'(lat), 2);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            frame_tick = tick_wait && (i == 1);
            if (i == 0) check("req_pulse", 32'(check_req), 0);
        end
        frame_tick = 1'b0;
        brick_done = 1'b1;
        brick_hit  = hit;
        @(negedge clk);
        brick_done = 1'b0;
        brick_hit  = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            do_tick();
            respond(1'b0, 1, 1'b0);
        end
    endtask

    task automatic wait_end(output int lat, output logic ll);
        lat = 0;
        ll  = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (life_lost) ll = 1'b1;
        end while (!(life_lost || game_over) && lat < 8);
    endtask

    initial begin
        int   lat;
        logic ll;

        // Reset values, asserted before any clock edge
        #2 reset = 1'b1;
        #2 check_reset_vals("rst");
        @(negedge clk);
        reset = 1'b0;

        // Serve tracks paddle with one cycle of latency; launch alone does nothing
        @(negedge clk);
        check_pos("serve", 114, 220);
        paddle_x = 9'd120;
        launch   = 1'b1;
        @(negedge clk);
        check("serve_track", 32'(ball_x), 134);
        paddle_x = 9'd100;
        @(negedge clk);
        check("serve_track2", 32'(ball_x), 114);

        do_tick();
        launch = 1'b0;
        check_pos("launch", 114, 220);
        check("launch_dx", 32'(dir_x), 1);
        check("launch_dy", 32'(dir_y), 0);
        paddle_x = 9'd50;
        @(negedge clk);
        check("move_no_track", 32'(ball_x), 114);
        paddle_x = 9'd100;

        // Frame 1
        do_tick();
        check_pos("f1", 116, 218);
        respond(1'b0, 1, 1'b0);

        // Frame 2: slow brick response with a hit and a dropped tick during WAIT
        do_tick();
        check_pos("f2", 118, 216);
        respond(1'b1, 5, 1'b1);
        check_pos("wait_tick", 118, 216);
        check("brick_toggle", 32'(dir_y), 1);
        repeat (3) @(negedge clk);
        check_pos("no_queued_tick", 118, 216);
        check("no_extra_req", 32'(check_req), 0);

        // Paddle bounce
        do_tick();
        check_pos("f3", 120, 218);
        respond(1'b0, 1, 1'b0);
        do_tick();
        check_pos("f4", 122, 220);
        check("f4_dy_pre", 32'(dir_y), 1);
        respond(1'b0, 1, 1'b0);
        check("bounce_dy", 32'(dir_y), 0);
        check("bounce_y", 32'(ball_y), 220);

        // Turn down again, move the paddle away, and lose the ball
        do_tick();
        respond(1'b1, 1, 1'b0);
        paddle_x = 9'd200;
        do_tick();
        check_pos("miss", 126, 220);
        respond(1'b0, 1, 1'b0);
        check("miss_dy", 32'(dir_y), 1);
        frames(7);
        check_pos("fall", 140, 234);
        do_tick();
        check_pos("floor", 142, 236);
        wait_end(lat, ll);
        check("lost1_lat", 32'(lat), 2);
        check("lost1_pulse", 32'(ll), 1);
        check("lost1_lives", 32'(lives), 2);
        check("lost1_over", 32'(game_over), 0);
        @(negedge clk);
        check("lost1_pulse_end", 32'(life_lost), 0);
        check_pos("reserve", 214, 220);

        // Corner: right wall and top wall struck on the same frame
        paddle_x = 9'd83;
        launch   = 1'b1;
        do_tick();
        launch = 1'b0;
        check_pos("serve2", 97, 220);
        frames(104);
        check_pos("pre_corner", 305, 12);
        do_tick();
        check_pos("near_corner", 307, 10);
        check("near_corner_dx", 32'(dir_x), 1);
        check("near_corner_dy", 32'(dir_y), 0);
        respond(1'b0, 1, 1'b0);
        do_tick();
        check_pos("corner", 308, 8);
        check("corner_dx", 32'(dir_x), 0);
        check("corner_dy", 32'(dir_y), 1);
        respond(1'b0, 1, 1'b0);

        // Descend onto the paddle, then travel to the left wall
        paddle_x = 9'd90;
        frames(106);
        check_pos("bounce2", 96, 220);
        check("bounce2_dy", 32'(dir_y), 0);
        frames(43);
        check_pos("pre_left", 10, 134);
        do_tick();
        check_pos("left", 8, 132);
        check("left_dx", 32'(dir_x), 1);
        respond(1'b0, 1, 1'b0);
        do_tick();
        check_pos("left_next", 10, 130);
        respond(1'b0, 1, 1'b0);

        // Second loss
        do_tick();
        respond(1'b1, 1, 1'b0);
        paddle_x = 9'd400;
        frames(53);
        check_pos("fall2", 118, 234);
        do_tick();
        wait_end(lat, ll);
        check("lost2_pulse", 32'(ll), 1);
        check("lost2_lives", 32'(lives), 1);
        @(negedge clk);
        check_pos("reserve2", 414, 220);

        // Third loss ends the game without a life_lost pulse
        paddle_x = 9'd10;
        launch   = 1'b1;
        do_tick();
        launch   = 1'b0;
        paddle_x = 9'd300;
        do_tick();
        check_pos("s3f1", 26, 218);
        respond(1'b1, 1, 1'b0);
        frames(8);
        check_pos("fall3", 42, 234);
        do_tick();
        wait_end(lat, ll);
        check("over_lat", 32'(lat), 2);
        check("over_flag", 32'(game_over), 1);
        check("over_lives", 32'(lives), 0);
        check("over_no_pulse", 32'(ll), 0);

        // Frozen in OVER
        launch   = 1'b1;
        paddle_x = 9'd50;
        do_tick();
        do_tick();
        repeat (3) @(negedge clk);
        launch = 1'b0;
        check_pos("frozen", 44, 236);
        check("frozen_over", 32'(game_over), 1);
        check("frozen_lives", 32'(lives), 0);
        check("frozen_req", 32'(check_req), 0);
        check("frozen_lost", 32'(life_lost), 0);

        // Mid-cycle asynchronous reset
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check_reset_vals("arst_over");
        @(negedge clk);
        reset    = 1'b0;
        paddle_x = 9'd100;
        @(negedge clk);
        check("post_rst_serve", 32'(ball_x), 114);

        // Reset with a brick query outstanding; the late done is ignored
        launch = 1'b1;
        do_tick();
        launch = 1'b0;
        do_tick();
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!check_req && lat < 10);
        check("wait_req", 32'(check_req), 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_vals("arst_wait");
        @(negedge clk);
        reset      = 1'b0;
        brick_done = 1'b1;
        brick_hit  = 1'b1;
        @(negedge clk);
        brick_done = 1'b0;
        brick_hit  = 1'b0;
        check("late_done_dy", 32'(dir_y), 0);
        check_pos("late_done", 114, 220);
        do_tick();
        paddle_x = 9'd120;
        @(negedge clk);
        check("still_serve", 32'(ball_x), 134);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ball_ctrl.md
# ball_ctrl

Frame-rate ball sequencer for Breakout. Each `frame_tick` it advances the ball, reflects it off the walls and the paddle, and queries the brick block through a request/done handshake. It also detects a ball lost past the paddle, manages serve and lives, and drives the ball position consumed by the renderer and brick logic.

## Interface
- `SCREEN_W`, 320: screen width, pixels
- `SCREEN_H`, 240: screen height, pixels
- `WALL`, 8: wall thickness on the left, top and right edges
- `BALL_SIZE`, 4: ball edge length; position is the top-left corner
- `PADDLE_Y`, 224: paddle top row
- `PADDLE_W`, 32: paddle width
- `STEP`, 2: pixels moved per axis per frame
- `LIVES`, 3: lives at reset (max 3)

Ports:
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high
- `frame_tick` in 1: one-cycle pulse, 60 Hz
- `launch` in 1: serve request (level)
- `paddle_x` in 9: paddle left edge
- `brick_done` in 1: brick block finished evaluating the current position
- `brick_hit` in 1: valid with `brick_done`; 1 means a brick was struck
- `ball_x` out 9, `ball_y` out 8: ball position
- `dir_x` out 1: 1 = right; `dir_y` out 1: 1 = down
- `check_req` out 1: one-cycle brick query pulse
- `life_lost` out 1: one-cycle pulse
- `lives` out 2: remaining lives
- `game_over` out 1: sticky until reset

## Operation
- Derived limits:
  - `LEFT = WALL` (8)
  - `TOP = WALL` (8)
  - `RIGHT = SCREEN_W-WALL-BALL_SIZE` (308)
  - `REST = PADDLE_Y-BALL_SIZE` (220)
  - `FLOOR = SCREEN_H-BALL_SIZE` (236)
- Arithmetic is done 10 bits wide; there is no underflow or wrap.

States:
- **SERVE**
  - Each cycle: `ball_x <= paddle_x + PADDLE_W/2 - BALL_SIZE/2`, `ball_y <= REST`.
  - On `frame_tick & launch`: `dir_x <= 1`, `dir_y <= 0`, go to MOVE.
- **MOVE**: wait for `frame_tick`. On the tick, update each axis, then go to EDGE.
  - x moving left: if `ball_x <= LEFT+STEP`, set `ball_x = LEFT` and `dir_x = 1`; else `ball_x -= STEP`.
  - x moving right: if `ball_x+STEP >= RIGHT`, set `ball_x = RIGHT` and `dir_x = 0`; else `ball_x += STEP`.
  - y moving up: if `ball_y <= TOP+STEP`, set `ball_y = TOP` and `dir_y = 1`; else `ball_y -= STEP`.
  - y moving down: `ball_y += STEP`, no clamp.
  - Both axes update in the same cycle, so a corner hit flips both directions.
- **EDGE** (1 cycle), priority order:
  - Paddle: if `dir_y=1`, `REST <= ball_y < REST+STEP`, `ball_x+BALL_SIZE > paddle_x` and `ball_x < paddle_x+PADDLE_W`, then `ball_y <= REST`, `dir_y <= 0`, go to REQ.
  - Else if `ball_y >= FLOOR`, go to LOST.
  - Else go to REQ.
- **REQ** (1 cycle): `check_req = 1`, go to WAIT.
- **WAIT**: hold until `brick_done`. If `brick_hit`, toggle `dir_y`. Go to MOVE.
- **LOST** (1 cycle): `lives <= lives-1`. If the result is 0, go to OVER; else pulse `life_lost` and go to SERVE.
- **OVER**: `game_over = 1`; position frozen. Only reset exits this state.

## Timing
- Reset values:
  - state SERVE
  - `ball_x = 158`, `ball_y = 220`
  - `dir_x = 1`, `dir_y = 0`
  - `lives = LIVES`
  - `check_req = 0`, `life_lost = 0`, `game_over = 0`
- Tick sampled in MOVE at edge T:
  - new position visible after edge T.
  - EDGE decision at T+1.
  - `check_req` high for the cycle after edge T+2.
  - Minimum return to MOVE at T+4.
- All outputs are registered.
- SERVE tracks `paddle_x` with 1-cycle latency.
- `brick_done` is sampled only in WAIT. The brick block must respond at least 1 cycle after `check_req`, with `brick_hit` stable while `brick_done` is high.
- `frame_tick` arriving outside MOVE or SERVE is dropped; that frame is skipped and no tick is queued.
- `launch` without `frame_tick` has no effect. `launch` is ignored outside SERVE.
- `life_lost` is high exactly one cycle, coincident with the return to SERVE.
- Asynchronous reset in any state, including WAIT with a request outstanding, restores all reset values immediately. A late `brick_done` after reset is ignored.

## Test plan
- Serve:
  - Setup: `paddle_x = 100`, `launch = 1`, one tick.
  - Before the tick: `ball_x = 114`, `ball_y = 220`.
  - After the tick: state MOVE, `dir_x = 1`, `dir_y = 0`.
  - After the next tick: `ball_x = 116`, `ball_y = 218`.
- Left wall:
  - Setup: `ball_x = 9`, `dir_x = 0`, one tick.
  - Expected: `ball_x = 8`, `dir_x = 1`.
  - Next tick: `ball_x = 10`.
- Corner:
  - Setup: `ball_x = 307`, `ball_y = 9`, moving right/up, one tick.
  - Expected: `ball_x = 308`, `ball_y = 8`, `dir_x = 0`, `dir_y = 1`, both flipped in the same cycle.
- Paddle bounce:
  - Setup: `ball_y = 218` moving down, `ball_x = 110`, `paddle_x = 100`, one tick.
  - Expected: `ball_y = 220`, then `dir_y = 0` after EDGE.
  - Repeat with `paddle_x = 200`: the ball continues down; at `ball_y >= 236`, `lives` goes 3→2, `life_lost` pulses and state returns to SERVE.
- Brick handshake:
  - `check_req` pulses once.
  - Hold `brick_done` low for 5 cycles, then assert it with `brick_hit = 1`.
  - Expected: `dir_y` toggles once; a tick arriving during WAIT does not move the ball.
- Game over and reset:
  - Lose 3 balls: `lives = 0`, `game_over = 1`, and ticks and `launch` have no effect.
  - Assert `reset` mid-cycle: all outputs return to reset values asynchronously.
